// File: rtl/decode_hazard_branch_unit_pkg.sv
// Shared decode constants for the D-stage hazard/branch helper.
package decode_hazard_branch_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned TIMING_W = 2;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM  = 6'h01;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ    = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ    = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI    = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU   = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI    = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU   = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI    = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI     = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI    = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI     = 6'h0F;
  localparam logic [OP_W-1:0] OP_COP0    = 6'h10;
  localparam logic [OP_W-1:0] OP_LB      = 6'h20;
  localparam logic [OP_W-1:0] OP_LH      = 6'h21;
  localparam logic [OP_W-1:0] OP_LW      = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU     = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU     = 6'h25;
  localparam logic [OP_W-1:0] OP_SB      = 6'h28;
  localparam logic [OP_W-1:0] OP_SH      = 6'h29;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MOVZ  = 6'h0A;
  localparam logic [5:0] FN_MOVN  = 6'h0B;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // REGIMM branch selectors carried in the rt field
  localparam logic [REG_W-1:0] RT_BLTZ   = 5'd0;
  localparam logic [REG_W-1:0] RT_BGEZ   = 5'd1;
  localparam logic [REG_W-1:0] RT_BLTZAL = 5'd16;
  localparam logic [REG_W-1:0] RT_BGEZAL = 5'd17;

  // COP0 move selectors carried in the rs field
  localparam logic [REG_W-1:0] RS_MFC0 = 5'd0;
  localparam logic [REG_W-1:0] RS_MTC0 = 5'd4;

  // Tuse: stage offset from D at which an operand is consumed
  localparam logic [TIMING_W-1:0] TUSE_D    = 2'd0;
  localparam logic [TIMING_W-1:0] TUSE_E    = 2'd1;
  localparam logic [TIMING_W-1:0] TUSE_M    = 2'd2;
  localparam logic [TIMING_W-1:0] TUSE_NONE = 2'd3;

  // Tnew: stage offset from D at which the result becomes forwardable
  localparam logic [TIMING_W-1:0] TNEW_D = 2'd0;
  localparam logic [TIMING_W-1:0] TNEW_E = 2'd1;
  localparam logic [TIMING_W-1:0] TNEW_M = 2'd2;

  // Three-operand R-type ALU ops (rs and rt both read in E)
  function automatic logic is_r_alu(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT, FN_SLTU: is_r_alu = 1'b1;
      default:                         is_r_alu = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_hazard_branch_unit_branch_cond_eval.sv
// Signed branch-condition evaluation on forwarded D-stage operands.
module branch_cond_eval
  import decode_hazard_branch_unit_pkg::*;
(
  input  logic [OP_W-1:0]  op_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic [XLEN-1:0]  rdata1_i,
  input  logic [XLEN-1:0]  rdata2_i,
  output logic             if_br_o
);

  logic lt_zero;
  logic eq_zero;

  // Sign bit and zero test give all signed compares against zero
  assign lt_zero = rdata1_i[XLEN-1];
  assign eq_zero = (rdata1_i == XLEN'(0));

  // Select the condition for the decoded branch; non-branches never take
  always_comb begin
    if_br_o = 1'b0;
    case (op_i)
      OP_BEQ:  if_br_o = (rdata1_i == rdata2_i);
      OP_BNE:  if_br_o = (rdata1_i != rdata2_i);
      OP_BLEZ: if_br_o = lt_zero | eq_zero;
      OP_BGTZ: if_br_o = ~lt_zero & ~eq_zero;
      OP_REGIMM: begin
        case (rt_i)
          RT_BLTZ, RT_BLTZAL: if_br_o = lt_zero;
          RT_BGEZ, RT_BGEZAL: if_br_o = ~lt_zero;
          default:            if_br_o = 1'b0;
        endcase
      end
      default: if_br_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_hazard_branch_unit.sv
// D-stage helper: hazard timing classification, branch condition and
// conditional write-enable. Purely combinational; clk/reset are unused.
module decode_hazard_branch_unit
  import decode_hazard_branch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  output logic        if_br,
  output logic        if_cdt_we,
  output logic [1:0]  tuse1,
  output logic [1:0]  tuse2,
  output logic [1:0]  tnew,
  output logic [4:0]  read_a1,
  output logic [4:0]  read_a2
);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [5:0]       funct;
  logic             unused_ok;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign funct = instr[5:0];

  // rd/shamt/immediate bits and the clock/reset pins carry no meaning here
  assign unused_ok = &{1'b0, clk, reset, instr[15:6]};

  branch_cond_eval u_branch_cond_eval (
    .op_i     (op),
    .rt_i     (rt),
    .rdata1_i (rdata1),
    .rdata2_i (rdata2),
    .if_br_o  (if_br)
  );

  // Conditional writes: movz/movn test rt, linking branches write when taken
  always_comb begin
    if_cdt_we = 1'b0;
    case (op)
      OP_SPECIAL: begin
        if (funct == FN_MOVZ)      if_cdt_we = (rdata2 == 32'd0);
        else if (funct == FN_MOVN) if_cdt_we = (rdata2 != 32'd0);
      end
      OP_REGIMM: begin
        if ((rt == RT_BLTZAL) || (rt == RT_BGEZAL)) if_cdt_we = if_br;
      end
      default: if_cdt_we = 1'b0;
    endcase
  end

  // Tuse/Tnew table; anything unrecognised reads nothing and writes nothing
  always_comb begin
    tuse1 = TUSE_NONE;
    tuse2 = TUSE_NONE;
    tnew  = TNEW_D;
    case (op)
      OP_SPECIAL: begin
        if (is_r_alu(funct)) begin
          tuse1 = TUSE_E;
          tuse2 = TUSE_E;
          tnew  = TNEW_E;
        end else begin
          case (funct)
            FN_SLL, FN_SRL, FN_SRA: begin
              tuse2 = TUSE_E;
              tnew  = TNEW_E;
            end
            FN_SLLV, FN_SRLV, FN_SRAV: begin
              tuse1 = TUSE_E;
              tuse2 = TUSE_E;
              tnew  = TNEW_E;
            end
            FN_JR: tuse1 = TUSE_D;
            FN_JALR: begin
              tuse1 = TUSE_D;
              tnew  = TNEW_D;
            end
            FN_MOVZ, FN_MOVN: begin
              tuse1 = TUSE_D;
              tuse2 = TUSE_D;
              tnew  = TNEW_E;
            end
            FN_MFHI, FN_MFLO: tnew = TNEW_E;
            FN_MTHI, FN_MTLO: tuse1 = TUSE_E;
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              tuse1 = TUSE_E;
              tuse2 = TUSE_E;
            end
            default: ;
          endcase
        end
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL: tuse1 = TUSE_D;
          default: ;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        tuse1 = TUSE_D;
        tuse2 = TUSE_D;
      end
      OP_BLEZ, OP_BGTZ: tuse1 = TUSE_D;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        tuse1 = TUSE_E;
        tnew  = TNEW_E;
      end
      // lui has no source register; its result is ready in D
      OP_LUI: tnew = TNEW_D;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        tuse1 = TUSE_E;
        tnew  = TNEW_M;
      end
      OP_SB, OP_SH, OP_SW: begin
        tuse1 = TUSE_E;
        tuse2 = TUSE_M;
      end
      OP_COP0: begin
        if (rs == RS_MFC0)      tnew  = TNEW_M;
        else if (rs == RS_MTC0) tuse2 = TUSE_M;
      end
      default: ;
    endcase
  end

  // Only registers actually read are reported to the stall unit
  assign read_a1 = (tuse1 != TUSE_NONE) ? rs : 5'd0;
  assign read_a2 = (tuse2 != TUSE_NONE) ? rt : 5'd0;

endmodule

// File: tb/tb_decode_hazard_branch_unit.sv
// Self-checking bench for decode_hazard_branch_unit: vector table driven
// through an expected-value queue, plus a reset-held sequence.
module tb_decode_hazard_branch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        if_br;
  logic        if_cdt_we;
  logic [1:0]  tuse1;
  logic [1:0]  tuse2;
  logic [1:0]  tnew;
  logic [4:0]  read_a1;
  logic [4:0]  read_a2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        br;
    logic        we;
    logic [1:0]  tu1;
    logic [1:0]  tu2;
    logic [1:0]  tn;
    logic [4:0]  a1;
    logic [4:0]  a2;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  decode_hazard_branch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .if_br     (if_br),
    .if_cdt_we (if_cdt_we),
    .tuse1     (tuse1),
    .tuse2     (tuse2),
    .tnew      (tnew),
    .read_a1   (read_a1),
    .read_a2   (read_a2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic vec_t mk(input string name, input logic rst, input logic [31:0] ins,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic br, input logic we, input logic [1:0] tu1,
                              input logic [1:0] tu2, input logic [1:0] tn,
                              input logic [4:0] a1, input logic [4:0] a2);
    vec_t v;
    v.name = name; v.rst = rst; v.instr = ins; v.r1 = r1; v.r2 = r2;
    v.br = br; v.we = we; v.tu1 = tu1; v.tu2 = tu2; v.tn = tn; v.a1 = a1; v.a2 = a2;
    return v;
  endfunction

  task automatic chk(input string name, input string field, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
    end
  endtask

  // Drive one vector and queue its expectation; compare on the falling edge
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    reset  = v.rst;
    instr  = v.instr;
    rdata1 = v.r1;
    rdata2 = v.r2;
    sb.push_back(v);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk(v.name, "scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk(e.name, "if_br",     int'(if_br),     int'(e.br));
      chk(e.name, "if_cdt_we", int'(if_cdt_we), int'(e.we));
      chk(e.name, "tuse1",     int'(tuse1),     int'(e.tu1));
      chk(e.name, "tuse2",     int'(tuse2),     int'(e.tu2));
      chk(e.name, "tnew",      int'(tnew),      int'(e.tn));
      chk(e.name, "read_a1",   int'(read_a1),   int'(e.a1));
      chk(e.name, "read_a2",   int'(read_a2),   int'(e.a2));
    end
  endtask

  initial begin
    reset = 1'b1; instr = 32'd0; rdata1 = 32'd0; rdata2 = 32'd0;

    //              name          rst  instr                                   r1            r2            br  we  tu1 tu2 tn  a1  a2
    vecs.push_back(mk("nop_rst",   1, 32'h0000_0000,                          32'd0,        32'd0,        0,  0,  3,  1,  1,  0,  0));
    vecs.push_back(mk("beq_eq",    0, itype(6'h04, 5'd1, 5'd2, 16'h0010),     32'h5,        32'h5,        1,  0,  0,  0,  0,  1,  2));
    vecs.push_back(mk("beq_ne",    0, itype(6'h04, 5'd1, 5'd2, 16'h0010),     32'h5,        32'h6,        0,  0,  0,  0,  0,  1,  2));
    vecs.push_back(mk("bne_ne",    0, itype(6'h05, 5'd1, 5'd2, 16'h0010),     32'h5,        32'h6,        1,  0,  0,  0,  0,  1,  2));
    vecs.push_back(mk("bgez_neg",  0, itype(6'h01, 5'd3, 5'd1, 16'h0004),     32'h8000_0000, 32'd0,       0,  0,  0,  3,  0,  3,  0));
    vecs.push_back(mk("bgez_zero", 0, itype(6'h01, 5'd3, 5'd1, 16'h0004),     32'd0,        32'd0,        1,  0,  0,  3,  0,  3,  0));
    vecs.push_back(mk("bltz_max",  0, itype(6'h01, 5'd3, 5'd0, 16'h0004),     32'h7FFF_FFFF, 32'd0,       0,  0,  0,  3,  0,  3,  0));
    vecs.push_back(mk("bltzal_m1", 0, itype(6'h01, 5'd4, 5'd16, 16'h0004),    32'hFFFF_FFFF, 32'd0,       1,  1,  0,  3,  0,  4,  0));
    vecs.push_back(mk("bgezal_m1", 0, itype(6'h01, 5'd4, 5'd17, 16'h0004),    32'hFFFF_FFFF, 32'd0,       0,  0,  0,  3,  0,  4,  0));
    vecs.push_back(mk("blez_zero", 0, itype(6'h06, 5'd2, 5'd0, 16'h0004),     32'd0,        32'd9,        1,  0,  0,  3,  0,  2,  0));
    vecs.push_back(mk("bgtz_zero", 0, itype(6'h07, 5'd2, 5'd0, 16'h0004),     32'd0,        32'd9,        0,  0,  0,  3,  0,  2,  0));
    vecs.push_back(mk("bgtz_one",  0, itype(6'h07, 5'd2, 5'd0, 16'h0004),     32'd1,        32'd9,        1,  0,  0,  3,  0,  2,  0));
    vecs.push_back(mk("lw",        0, itype(6'h23, 5'd9, 5'd8, 16'h0004),     32'd0,        32'd0,        0,  0,  1,  3,  2,  9,  0));
    vecs.push_back(mk("sw",        0, itype(6'h2B, 5'd9, 5'd8, 16'h0000),     32'd0,        32'd0,        0,  0,  1,  2,  0,  9,  8));
    vecs.push_back(mk("movz_z",    0, rtype(5'd4, 5'd5, 5'd3, 6'h0A),         32'd1,        32'd0,        0,  1,  0,  0,  1,  4,  5));
    vecs.push_back(mk("movz_nz",   0, rtype(5'd4, 5'd5, 5'd3, 6'h0A),         32'd1,        32'd7,        0,  0,  0,  0,  1,  4,  5));
    vecs.push_back(mk("movn_nz",   0, rtype(5'd4, 5'd5, 5'd3, 6'h0B),         32'd1,        32'd7,        0,  1,  0,  0,  1,  4,  5));
    vecs.push_back(mk("addu",      0, rtype(5'd2, 5'd3, 5'd1, 6'h21),         32'd5,        32'd5,        0,  0,  1,  1,  1,  2,  3));
    vecs.push_back(mk("jr",        0, rtype(5'd31, 5'd0, 5'd0, 6'h08),        32'd0,        32'd0,        0,  0,  0,  3,  0,  31, 0));
    vecs.push_back(mk("jal",       0, {6'h03, 26'h0000123},                   32'd0,        32'd0,        0,  0,  3,  3,  0,  0,  0));
    vecs.push_back(mk("mfc0",      0, {6'h10, 5'd0, 5'd7, 5'd12, 11'd0},      32'd0,        32'd0,        0,  0,  3,  3,  2,  0,  0));
    vecs.push_back(mk("mtc0",      0, {6'h10, 5'd4, 5'd7, 5'd12, 11'd0},      32'd0,        32'd0,        0,  0,  3,  2,  0,  0,  7));
    vecs.push_back(mk("lui",       0, itype(6'h0F, 5'd0, 5'd5, 16'h1234),     32'd0,        32'd0,        0,  0,  3,  3,  0,  0,  0));
    vecs.push_back(mk("undef_3f",  0, itype(6'h3F, 5'd5, 5'd6, 16'h0000),     32'd0,        32'd0,        0,  0,  3,  3,  0,  0,  0));
    vecs.push_back(mk("nop",       0, 32'h0000_0000,                          32'd0,        32'd0,        0,  0,  3,  1,  1,  0,  0));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset raised mid-stream must leave every output unchanged
    apply(mk("rst_bltzal", 1, itype(6'h01, 5'd4, 5'd16, 16'h0004), 32'hFFFF_FFFF, 32'd0, 1, 1, 0, 3, 0, 4, 0));
    apply(mk("rst_movz",   1, rtype(5'd4, 5'd5, 5'd3, 6'h0A),      32'd1,         32'd0, 0, 1, 0, 0, 1, 4, 5));
    apply(mk("rst_lw",     1, itype(6'h23, 5'd9, 5'd8, 16'h0004),  32'd0,         32'd0, 0, 0, 1, 3, 2, 9, 0));
    apply(mk("post_rst",   0, itype(6'h04, 5'd1, 5'd2, 16'h0010),  32'h5,         32'h5, 1, 0, 0, 0, 0, 1, 2));

    // Operands change with the instruction held: outputs track same cycle
    apply(mk("beq_hold_a", 0, itype(6'h04, 5'd7, 5'd7, 16'h0000),  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 7, 7));
    apply(mk("beq_hold_b", 0, itype(6'h04, 5'd7, 5'd7, 16'h0000),  32'hDEAD_BEEF, 32'hDEAD_BEEE, 0, 0, 0, 0, 0, 7, 7));

    chk("final", "scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
